// File: rtl/nfc_stream_pkg.sv
// Shared definitions for the NAND read-stream packing path: halfword keep
// patterns, the legal output widths and a 2-bit popcount.
package nfc_stream_pkg;

  localparam logic [1:0] KEEP_FULL = 2'b11;
  localparam logic [1:0] KEEP_LOW  = 2'b01;
  localparam logic [1:0] KEEP_NONE = 2'b00;

  function automatic bit legal_out_bytes(input int unsigned n);
    return (n == 4) || (n == 8) || (n == 16);
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] k);
    return {1'b0, k[0]} + {1'b0, k[1]};
  endfunction

endpackage

// File: rtl/nfc_read_stream_packer_if.sv
// Halfword input stream and packed-word output stream of the read packer.
interface nfc_read_stream_packer_if #(
  parameter int unsigned OUT_BYTES = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [15:0]            in_data;
  logic [1:0]             in_keep;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*OUT_BYTES-1:0] out_data;
  logic [OUT_BYTES-1:0]   out_keep;
  logic                   out_last;

  modport slave (
    input  in_valid, in_data, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/nfc_stream_skid2.sv
// Two-entry valid/ready buffer; the upstream ready is registered so it has
// no combinational dependency on pop_ready.
module nfc_stream_skid2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop     = pop_valid & pop_ready;
    do_push    = push & ((count != 2'd2) | do_pop);
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  assign pop_valid = (count != 2'd0);
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      ready  <= 1'b0;
    end else if (flush) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
      // Ready mirrors "not full" for the state being entered this edge.
      ready <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/nfc_read_stream_packer.sv
// Packs 16-bit NAND read beats into OUT_BYTES-wide words, counts bytes per
// frame and flags length and keep-pattern errors.
module nfc_read_stream_packer
  import nfc_stream_pkg::*;
#(
  parameter int unsigned OUT_BYTES   = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   iSystemClock,
  input  logic                   iModuleReset_n,
  input  logic                   iFlush,
  input  logic [COUNT_WIDTH-1:0] iExpectedBytes,
  output logic                   oFrameDone,
  output logic [COUNT_WIDTH-1:0] oFrameBytes,
  output logic                   oLengthError,
  output logic                   oKeepError,
  nfc_read_stream_packer_if.slave bus
);

  localparam int unsigned SLOTS  = OUT_BYTES / 2;
  localparam int unsigned IDX_W  = $clog2(SLOTS);
  localparam int unsigned WORD_W = 8 * OUT_BYTES + OUT_BYTES + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

  if (!legal_out_bytes(OUT_BYTES)) begin : g_bad_out_bytes
    $error("nfc_read_stream_packer: OUT_BYTES must be 4, 8 or 16");
  end

  logic [8*OUT_BYTES-1:0] acc_data;
  logic [OUT_BYTES-1:0]   acc_keep;
  logic [IDX_W-1:0]       idx;
  logic [COUNT_WIDTH-1:0] byte_cnt;

  logic                   beat;
  logic                   keep_legal;
  logic [1:0]             eff_keep;
  logic [15:0]            slot_data;
  logic [8*OUT_BYTES-1:0] next_data;
  logic [OUT_BYTES-1:0]   next_keep;
  logic                   push_word;
  logic [COUNT_WIDTH:0]   sum_wide;
  logic [COUNT_WIDTH-1:0] cnt_next;
  logic [WORD_W-1:0]      head;

  always_comb begin
    beat       = bus.in_valid & bus.in_ready & ~iFlush;
    keep_legal = (bus.in_keep == KEEP_FULL) ||
                 (bus.in_last && ((bus.in_keep == KEEP_LOW) || (bus.in_keep == KEEP_NONE)));
    eff_keep   = keep_legal ? bus.in_keep : KEEP_FULL;
    slot_data  = {eff_keep[1] ? bus.in_data[15:8] : 8'h00,
                  eff_keep[0] ? bus.in_data[7:0]  : 8'h00};
    next_data  = acc_data;
    next_keep  = acc_keep;
    next_data[idx*16 +: 16] = slot_data;
    next_keep[idx*2 +: 2]   = eff_keep;
    push_word  = beat & (bus.in_last | (idx == LAST_IDX));
    sum_wide   = {1'b0, byte_cnt} + {{(COUNT_WIDTH-1){1'b0}}, popcount2(eff_keep)};
    cnt_next   = sum_wide[COUNT_WIDTH] ? '1 : sum_wide[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
    if (!iModuleReset_n) begin
      acc_data     <= '0;
      acc_keep     <= '0;
      idx          <= '0;
      byte_cnt     <= '0;
      oFrameBytes  <= '0;
      oFrameDone   <= 1'b0;
      oLengthError <= 1'b0;
      oKeepError   <= 1'b0;
    end else if (iFlush) begin
      acc_data     <= '0;
      acc_keep     <= '0;
      idx          <= '0;
      byte_cnt     <= '0;
      oFrameBytes  <= '0;
      oFrameDone   <= 1'b0;
      oLengthError <= 1'b0;
      oKeepError   <= 1'b0;
    end else begin
      oFrameDone   <= 1'b0;
      oLengthError <= 1'b0;
      if (beat) begin
        if (!keep_legal) begin
          oKeepError <= 1'b1;
        end
        // A pushed word leaves the accumulator zeroed so partial words pad with 0.
        if (push_word) begin
          acc_data <= '0;
          acc_keep <= '0;
          idx      <= '0;
        end else begin
          acc_data <= next_data;
          acc_keep <= next_keep;
          idx      <= idx + 1'b1;
        end
        if (bus.in_last) begin
          oFrameBytes  <= cnt_next;
          byte_cnt     <= '0;
          oFrameDone   <= 1'b1;
          oLengthError <= (iExpectedBytes != '0) && (cnt_next != iExpectedBytes);
        end else begin
          byte_cnt <= cnt_next;
        end
      end
    end
  end

  nfc_stream_skid2 #(
    .WIDTH(WORD_W)
  ) u_out_buf (
    .clk       (iSystemClock),
    .rst_n     (iModuleReset_n),
    .flush     (iFlush),
    .push      (push_word),
    .push_data ({next_data, next_keep, bus.in_last}),
    .ready     (bus.in_ready),
    .pop_valid (bus.out_valid),
    .pop_ready (bus.out_ready),
    .pop_data  (head)
  );

  assign {bus.out_data, bus.out_keep, bus.out_last} = head;

endmodule
